// File: rtl/hdmi_i2c_config.sv
// ADV7513 power-up configuration master. It writes a fixed register table over I2C at about 100 kHz.
// I2C_BUSY stays high until every entry has been acknowledged; RECONFIG re-runs the table from DONE or ERROR.
`timescale 1ns/1ps
module hdmi_i2c_config #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [7:0]  DEV_ADDR = 8'h72,
    parameter int unsigned RETRIES  = 3,
    parameter int unsigned GAP_QTR  = 8
) (
    input  logic REF_CLK50,
    input  logic RESET_HDMI,
    input  logic RECONFIG,
    output logic I2C_SCL,
    inout  wire  I2C_SDA,
    output logic I2C_BUSY,
    output logic CONFIG_ERR
);
    localparam logic [7:0] TICK_MAX  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_MAX   = 8'(GAP_QTR - 1);
    localparam logic [2:0] RETRY_MAX = 3'(RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_STOP, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t      state_reg;
    logic [7:0]  tick_reg;
    logic [1:0]  qstep_reg;
    logic [3:0]  bit_reg;
    logic [1:0]  byte_reg;
    logic [3:0]  idx_reg;
    logic [2:0]  retry_reg;
    logic [7:0]  gap_reg;
    logic        ack_reg;
    logic        entry_ok_reg;
    logic        fail_reg;
    logic        scl_reg;
    logic        sda_oe_reg;
    logic        busy_reg;
    logic        err_reg;

    logic        running;
    logic        qtick;
    logic [15:0] entry;
    logic [7:0]  tx_byte;
    logic        tx_bit;

    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = 16'h4110;
            4'd1:    table_entry = 16'h9803;
            4'd2:    table_entry = 16'h9AE0;
            4'd3:    table_entry = 16'h9C30;
            4'd4:    table_entry = 16'h9D61;
            4'd5:    table_entry = 16'hA2A4;
            4'd6:    table_entry = 16'hA3A4;
            4'd7:    table_entry = 16'hE0D0;
            4'd8:    table_entry = 16'hF900;
            4'd9:    table_entry = 16'h1500;
            4'd10:   table_entry = 16'h1630;
            4'd11:   table_entry = 16'hAF06;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    assign running = (state_reg != S_IDLE) && (state_reg != S_DONE) && (state_reg != S_ERROR);
    assign qtick   = running && (tick_reg == TICK_MAX);

    always_comb begin
        entry = table_entry(idx_reg);
        case (byte_reg)
            2'd0:    tx_byte = DEV_ADDR;
            2'd1:    tx_byte = entry[15:8];
            default: tx_byte = entry[7:0];
        endcase
    end

    // MSB first: bit 0 of the byte stream selects tx_byte[7].
    assign tx_bit = tx_byte[~bit_reg[2:0]];

    always_ff @(posedge REF_CLK50) begin
        if (RESET_HDMI) begin
            state_reg    <= S_IDLE;
            tick_reg     <= 8'd0;
            qstep_reg    <= 2'd0;
            bit_reg      <= 4'd0;
            byte_reg     <= 2'd0;
            idx_reg      <= 4'd0;
            retry_reg    <= 3'd0;
            gap_reg      <= 8'd0;
            ack_reg      <= 1'b0;
            entry_ok_reg <= 1'b0;
            fail_reg     <= 1'b0;
            scl_reg      <= 1'b1;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            if (running)
                tick_reg <= qtick ? 8'd0 : tick_reg + 8'd1;
            else
                tick_reg <= 8'd0;

            case (state_reg)
                S_IDLE: begin
                    qstep_reg <= 2'd0;
                    state_reg <= S_START;
                end
                S_START: if (qtick) begin
                    if (qstep_reg == 2'd0) begin
                        sda_oe_reg <= 1'b1;
                        qstep_reg  <= 2'd1;
                    end else begin
                        scl_reg   <= 1'b0;
                        qstep_reg <= 2'd0;
                        bit_reg   <= 4'd0;
                        byte_reg  <= 2'd0;
                        state_reg <= S_BYTE;
                    end
                end
                S_BYTE: if (qtick) begin
                    qstep_reg <= qstep_reg + 2'd1;
                    case (qstep_reg)
                        2'd0: sda_oe_reg <= (bit_reg == 4'd8) ? 1'b0 : ~tx_bit;
                        2'd1: scl_reg <= 1'b1;
                        2'd2: if (bit_reg == 4'd8) ack_reg <= ~I2C_SDA;
                        default: begin
                            scl_reg <= 1'b0;
                            if (bit_reg != 4'd8) begin
                                bit_reg <= bit_reg + 4'd1;
                            end else begin
                                bit_reg <= 4'd0;
                                if (!ack_reg) begin
                                    state_reg    <= S_STOP;
                                    entry_ok_reg <= 1'b0;
                                    if (retry_reg >= RETRY_MAX) begin
                                        fail_reg <= 1'b1;
                                        err_reg  <= 1'b1;
                                    end else begin
                                        retry_reg <= retry_reg + 3'd1;
                                    end
                                end else if (byte_reg != 2'd2) begin
                                    byte_reg <= byte_reg + 2'd1;
                                end else begin
                                    state_reg    <= S_STOP;
                                    entry_ok_reg <= 1'b1;
                                    retry_reg    <= 3'd0;
                                end
                            end
                        end
                    endcase
                end
                S_STOP: if (qtick) begin
                    case (qstep_reg)
                        2'd0: begin
                            sda_oe_reg <= 1'b1;
                            qstep_reg  <= 2'd1;
                        end
                        2'd1: begin
                            scl_reg   <= 1'b1;
                            qstep_reg <= 2'd2;
                        end
                        default: begin
                            sda_oe_reg <= 1'b0;
                            qstep_reg  <= 2'd0;
                            gap_reg    <= 8'd0;
                            state_reg  <= fail_reg ? S_ERROR : S_GAP;
                        end
                    endcase
                end
                S_GAP: if (qtick) begin
                    if (gap_reg != GAP_MAX) begin
                        gap_reg <= gap_reg + 8'd1;
                    end else begin
                        gap_reg <= 8'd0;
                        if (entry_ok_reg && idx_reg == 4'd11) begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                        end else begin
                            if (entry_ok_reg)
                                idx_reg <= idx_reg + 4'd1;
                            state_reg <= S_START;
                        end
                    end
                end
                S_DONE, S_ERROR: if (RECONFIG) begin
                    idx_reg   <= 4'd0;
                    retry_reg <= 3'd0;
                    err_reg   <= 1'b0;
                    fail_reg  <= 1'b0;
                    busy_reg  <= 1'b1;
                    qstep_reg <= 2'd0;
                    state_reg <= S_START;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign I2C_SCL    = scl_reg;
    assign I2C_SDA    = sda_oe_reg ? 1'b0 : 1'bz;
    assign I2C_BUSY   = busy_reg;
    assign CONFIG_ERR = err_reg;
endmodule

// File: tb/tb_hdmi_i2c_config.sv
// Bench for hdmi_i2c_config. An I2C slave/monitor decodes every write against an expected queue.
// A timeline model derived from transaction lengths predicts I2C_BUSY, CONFIG_ERR and bus idle on every cycle.
`timescale 1ns/1ps
module tb_hdmi_i2c_config;
    localparam int CLK_DIV = 4;
    localparam int GAP_QTR = 8;
    localparam int RETRIES = 3;
    localparam int TXN_Q   = 2 + 27*4 + 3 + GAP_QTR;   // full write, in quarter ticks
    localparam int NACK_Q  = 2 + 9*4 + 3 + GAP_QTR;    // address-only attempt
    localparam int NEVER   = 32'h7fff_ffff;

    logic REF_CLK50  = 1'b0;
    logic RESET_HDMI = 1'b1;
    logic RECONFIG   = 1'b0;
    logic I2C_SCL;
    logic I2C_BUSY;
    logic CONFIG_ERR;
    wire  i2c_sda;
    logic slave_pull = 1'b0;

    assign i2c_sda = slave_pull ? 1'b0 : 1'bz;
    pullup (i2c_sda);

    hdmi_i2c_config #(
        .CLK_DIV (CLK_DIV),
        .DEV_ADDR(8'h72),
        .RETRIES (RETRIES),
        .GAP_QTR (GAP_QTR)
    ) dut (
        .REF_CLK50 (REF_CLK50),
        .RESET_HDMI(RESET_HDMI),
        .RECONFIG  (RECONFIG),
        .I2C_SCL   (I2C_SCL),
        .I2C_SDA   (i2c_sda),
        .I2C_BUSY  (I2C_BUSY),
        .CONFIG_ERR(CONFIG_ERR)
    );

    always #5 REF_CLK50 = ~REF_CLK50;

    logic [15:0] tbl [12] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
                              16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
                              16'hF900, 16'h1500, 16'h1630, 16'hAF06};

    int n_vec = 0;
    int n_err = 0;

    // timeline model, in posedges counted from the run's start edge
    int edge_cnt = 0;
    bit m_on     = 1'b0;
    int m_s      = 0;
    int m_done_k = NEVER;
    int m_err_k  = NEVER;
    int m_idle_k = NEVER;

    logic [31:0] exp_q [$];
    int          txn_cnt = 0;
    logic [31:0] first_txn = '0;
    logic [31:0] last_txn  = '0;

    // slave configuration
    int addr_seen = 0;
    int nack_at   = -1;
    bit nack_all  = 1'b0;

    // monitor state
    bit          prev_scl = 1'b1;
    bit          prev_sda = 1'b1;
    bit          in_txn   = 1'b0;
    int          mon_bitpos = 0;
    int          mon_nb     = 0;
    logic [7:0]  mon_shift  = '0;
    logic [23:0] mon_bytes  = '0;
    bit          slave_nack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_run(input int nack_idx, input bit all_nack);
        int total;
        exp_q.delete();
        nack_at   = nack_idx;
        nack_all  = all_nack;
        addr_seen = 0;
        txn_cnt   = 0;
        if (all_nack) begin
            for (int a = 0; a <= RETRIES; a++) exp_q.push_back(32'h0100_0072);
            m_done_k = NEVER;
            m_err_k  = (RETRIES*NACK_Q + 2 + 9*4) * CLK_DIV;
            m_idle_k = m_err_k + 3*CLK_DIV;
        end else begin
            for (int e = 0; e < 12; e++) begin
                if (e == nack_idx) exp_q.push_back(32'h0100_0072);
                exp_q.push_back({8'd3, 8'h72, tbl[e]});
            end
            total    = 12*TXN_Q + ((nack_idx >= 0) ? NACK_Q : 0);
            m_done_k = total * CLK_DIV;
            m_err_k  = NEVER;
            m_idle_k = m_done_k;
        end
        m_s  = edge_cnt + 1;
        m_on = 1'b1;
    endtask

    task automatic pulse_reconfig();
        RECONFIG = 1'b1;
        @(negedge REF_CLK50);
        RECONFIG = 1'b0;
    endtask

    task automatic wait_busy_low(input string name, input int budget, output int k_at);
        int n = 0;
        while (I2C_BUSY !== 1'b0 && n < budget) begin
            @(negedge REF_CLK50);
            n++;
        end
        k_at = (I2C_BUSY === 1'b0) ? edge_cnt - m_s : -1;
        check(name, 32'(I2C_BUSY), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) @(negedge REF_CLK50);
    endtask

    // per-cycle comparison against the timeline model
    always begin
        int k;
        @(posedge REF_CLK50);
        edge_cnt++;
        #1;
        if (m_on && edge_cnt >= m_s) begin
            k = edge_cnt - m_s;
            check("busy_cycle", 32'(I2C_BUSY), (k >= m_done_k) ? 32'd0 : 32'd1);
            check("err_cycle", 32'(CONFIG_ERR), (k >= m_err_k) ? 32'd1 : 32'd0);
            if (k >= m_idle_k) check("bus_idle", {30'd0, I2C_SCL, i2c_sda}, 32'd3);
        end
    end

    // I2C slave and transaction decoder
    always begin
        bit scl;
        bit sda;
        logic [31:0] rec;
        @(posedge REF_CLK50);
        #1;
        if (RESET_HDMI) begin
            prev_scl = 1'b1; prev_sda = 1'b1; in_txn = 1'b0;
            mon_bitpos = 0; mon_nb = 0; slave_pull = 1'b0;
        end else begin
            scl = I2C_SCL;
            sda = i2c_sda;
            if (prev_scl && scl && prev_sda && !sda) begin
                in_txn = 1'b1; mon_nb = 0; mon_bitpos = 0; mon_bytes = '0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                if (in_txn) begin
                    rec = {8'(mon_nb), mon_bytes};
                    $display("txn %0d: %0d byte(s) %06h", txn_cnt, mon_nb, mon_bytes);
                    if (txn_cnt == 0) first_txn = rec;
                    last_txn = rec;
                    txn_cnt++;
                    if (exp_q.size() == 0) check("txn_unexpected", rec, 32'd0);
                    else check("txn", rec, exp_q.pop_front());
                end
                in_txn = 1'b0;
            end else if (!prev_scl && scl && in_txn) begin
                if (mon_bitpos < 8) mon_shift = {mon_shift[6:0], sda};
                mon_bitpos++;
                if (mon_bitpos == 8) begin
                    mon_bytes = {mon_bytes[15:0], mon_shift};
                    mon_nb++;
                    slave_nack = 1'b0;
                    if (mon_nb == 1) begin
                        slave_nack = nack_all || (addr_seen == nack_at);
                        addr_seen++;
                    end
                end
            end else if (prev_scl && !scl && in_txn) begin
                if (mon_bitpos == 8) slave_pull = !slave_nack;
                else if (mon_bitpos == 9) begin
                    slave_pull = 1'b0;
                    mon_bitpos = 0;
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    initial begin
        int k_at;
        int n;

        // reset held for five cycles
        for (int c = 0; c < 5; c++) begin
            @(negedge REF_CLK50);
            check("rst_scl", 32'(I2C_SCL), 32'd1);
            check("rst_sda", 32'(i2c_sda), 32'd1);
            check("rst_busy", 32'(I2C_BUSY), 32'd1);
            check("rst_err", 32'(CONFIG_ERR), 32'd0);
        end
        start_run(-1, 1'b0);
        RESET_HDMI = 1'b0;
        for (int c = 0; c < CLK_DIV + 1 && i2c_sda !== 1'b0; c++) @(negedge REF_CLK50);
        check("start_sda_fall", 32'(i2c_sda), 32'd0);

        // full table with an always-ACK slave
        wait_busy_low("full_done", 13*TXN_Q*CLK_DIV, k_at);
        check("full_done_edge", k_at, 32'd5808);
        check("full_first_txn", first_txn, 32'h0372_4110);
        check("full_last_txn", last_txn, 32'h0372_AF06);
        check("full_left", exp_q.size(), 32'd0);
        idle_cycles(200);

        // single NACK on entry 3 address, started by RECONFIG in DONE
        start_run(3, 1'b0);
        pulse_reconfig();
        check("busy_after_reconfig", 32'(I2C_BUSY), 32'd1);
        wait_busy_low("nack1_done", 14*TXN_Q*CLK_DIV, k_at);
        check("nack1_done_edge", k_at, 32'd6004);
        check("nack1_err", 32'(CONFIG_ERR), 32'd0);
        check("nack1_left", exp_q.size(), 32'd0);
        idle_cycles(100);

        // permanent NACK on entry 0
        start_run(-1, 1'b1);
        pulse_reconfig();
        n = 0;
        while (CONFIG_ERR !== 1'b1 && n < 6*NACK_Q*CLK_DIV) begin
            @(negedge REF_CLK50);
            n++;
        end
        check("perm_err_edge", edge_cnt - m_s, 32'd740);
        idle_cycles(300);
        check("perm_err_sticky", 32'(CONFIG_ERR), 32'd1);
        check("perm_busy", 32'(I2C_BUSY), 32'd1);
        check("perm_attempts", txn_cnt, 32'd4);
        check("perm_left", exp_q.size(), 32'd0);

        // RECONFIG from ERROR clears the error and repeats the full table
        start_run(-1, 1'b0);
        pulse_reconfig();
        check("recfg_err_clear", 32'(CONFIG_ERR), 32'd0);
        check("recfg_busy", 32'(I2C_BUSY), 32'd1);
        wait_busy_low("recfg_done", 13*TXN_Q*CLK_DIV, k_at);
        check("recfg_done_edge", k_at, 32'd5808);
        check("recfg_first_txn", first_txn, 32'h0372_4110);
        check("recfg_left", exp_q.size(), 32'd0);
        idle_cycles(100);

        // RECONFIG ignored mid-byte, then reset inside entry 5 data byte
        start_run(-1, 1'b0);
        pulse_reconfig();
        check("busy_after_reconfig2", 32'(I2C_BUSY), 32'd1);
        n = 0;
        while (!(txn_cnt == 2 && mon_nb >= 1) && n < 4*TXN_Q*CLK_DIV) begin
            @(negedge REF_CLK50);
            n++;
        end
        check("reach_entry2", txn_cnt, 32'd2);
        pulse_reconfig();
        n = 0;
        while (!(txn_cnt == 5 && mon_nb == 2 && mon_bitpos == 5) && n < 5*TXN_Q*CLK_DIV) begin
            @(negedge REF_CLK50);
            n++;
        end
        check("reach_e5_txns", txn_cnt, 32'd5);
        check("reach_e5_bit", mon_bitpos, 32'd5);
        RESET_HDMI = 1'b1;
        m_on = 1'b0;
        @(posedge REF_CLK50);
        #1;
        check("midrst_scl", 32'(I2C_SCL), 32'd1);
        check("midrst_sda", 32'(i2c_sda), 32'd1);
        idle_cycles(3);
        start_run(-1, 1'b0);
        RESET_HDMI = 1'b0;
        wait_busy_low("restart_done", 13*TXN_Q*CLK_DIV, k_at);
        check("restart_done_edge", k_at, 32'd5808);
        check("restart_first_txn", first_txn, 32'h0372_4110);
        check("restart_left", exp_q.size(), 32'd0);
        idle_cycles(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
